// File: rtl/pipe_pkg.sv
// Shared pipeline constants: per-stage bundle widths, NOP control encoding and
// data lane indices used by every stage boundary register.
package pipe_pkg;

  localparam int unsigned STAGE_DATA_W    = 8;

  localparam int unsigned ID_EX_CTRL_W    = 24;
  localparam int unsigned ID_EX_NUM_DATA  = 8;
  localparam int unsigned EX_MEM_CTRL_W   = 16;
  localparam int unsigned EX_MEM_NUM_DATA = 4;
  localparam int unsigned MEM_WB_CTRL_W   = 8;
  localparam int unsigned MEM_WB_NUM_DATA = 3;

  // Widest control bundle any stage may carry; a NOP is all-zero at every width.
  localparam int unsigned CTRL_MAX_W = 64;
  localparam logic [CTRL_MAX_W-1:0] CTRL_NOP = '0;

  localparam int unsigned LANE_RD1    = 0;
  localparam int unsigned LANE_RD2    = 1;
  localparam int unsigned LANE_IMM    = 2;
  localparam int unsigned LANE_PC     = 3;
  localparam int unsigned LANE_PC1    = 4;
  localparam int unsigned LANE_SP     = 5;
  localparam int unsigned LANE_SP12   = 6;
  localparam int unsigned LANE_INPORT = 7;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register with valid/ready handshake, flush-to-NOP
// and a stall/bubble counter. Define PIPE_STAGE_SKID_EN for a one-entry skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W   = ID_EX_CTRL_W,
  parameter int unsigned DATA_W   = STAGE_DATA_W,
  parameter int unsigned NUM_DATA = ID_EX_NUM_DATA,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          ctrl_in,
  input  logic [NUM_DATA*DATA_W-1:0] data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          ctrl_out,
  output logic [NUM_DATA*DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]           stall_cnt,
  input  logic                       clr_cnt
);

  localparam int unsigned LANES_W = NUM_DATA * DATA_W;

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [LANES_W-1:0] data;
  } entry_t;

  localparam entry_t ENTRY_NOP = '{ctrl: CTRL_W'(CTRL_NOP), data: '0};

  entry_t incoming;
  entry_t main_q, main_d;
  logic   main_vld_q, main_vld_d;
  logic   xfer_in;
  logic   cnt_inc;

`ifdef PIPE_STAGE_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_vld_q, skid_vld_d;
`endif

  assign incoming = '{ctrl: ctrl_in, data: data_in};
  assign xfer_in  = in_valid && in_ready;

  // Flush reports ready so upstream retires the entry being discarded.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = 1'b0;
    end else if (flush) begin
      in_ready = 1'b1;
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      in_ready = !skid_vld_q;
`else
      in_ready = out_ready || !main_vld_q;
`endif
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // Main slot refills from skid first so ordering is preserved.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_d     = ENTRY_NOP;
      main_vld_d = 1'b0;
      skid_d     = ENTRY_NOP;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_ready) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        if (xfer_in) begin
          skid_d = incoming;
        end else begin
          skid_d     = ENTRY_NOP;
          skid_vld_d = 1'b0;
        end
      end else if (xfer_in) begin
        main_d     = incoming;
        main_vld_d = 1'b1;
      end else begin
        main_d     = ENTRY_NOP;
        main_vld_d = 1'b0;
      end
    end else if (xfer_in) begin
      skid_d     = incoming;
      skid_vld_d = 1'b1;
    end
  end
`else
  // Single slot: load on accept, clear to NOP on drain, otherwise hold.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    if (flush) begin
      main_d     = ENTRY_NOP;
      main_vld_d = 1'b0;
    end else if (xfer_in) begin
      main_d     = incoming;
      main_vld_d = 1'b1;
    end else if (main_vld_q && out_ready) begin
      main_d     = ENTRY_NOP;
      main_vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_q     <= ENTRY_NOP;
      main_vld_q <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q     <= ENTRY_NOP;
      skid_vld_q <= 1'b0;
`endif
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
`endif
    end
  end

  assign out_valid = main_vld_q;
  assign ctrl_out  = main_q.ctrl;
  assign data_out  = main_q.data;

  // Stalled-full or bubble cycles are counted; flush cycles are not.
  assign cnt_inc = !flush && (!main_vld_q || !out_ready);

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (cnt_inc),
    .clr  (clr_cnt),
    .cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations. Works with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  localparam int unsigned CW = 24;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready, clr_cnt;
  logic [CW-1:0] ctrl_in;
  logic [DW-1:0] data_in;

  logic          in_ready, out_valid;
  logic [CW-1:0] ctrl_out;
  logic [DW-1:0] data_out;
  logic [7:0]    stall_cnt;

  logic          s_in_ready, s_out_valid;
  logic [CW-1:0] s_ctrl_out;
  logic [DW-1:0] s_data_out;
  logic [2:0]    s_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CW+DW-1:0] q[$];
  int unsigned      m_cnt8 = 0;
  int unsigned      m_cnt3 = 0;
  bit               m_acc, m_inc;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .data_out(data_out), .stall_cnt(stall_cnt), .clr_cnt(clr_cnt)
  );

  pipe_stage_reg #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .ctrl_in(ctrl_in), .data_in(data_in), .out_valid(s_out_valid), .out_ready(out_ready),
    .ctrl_out(s_ctrl_out), .data_out(s_data_out), .stall_cnt(s_stall_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_in_ready();
    if (!reset) return 1'b0;
    if (flush) return 1'b1;
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return out_ready || (q.size() == 0);
`endif
  endfunction

  function automatic logic [CW+DW-1:0] m_front();
    if (q.size() == 0) return '0;
    return q[0];
  endfunction

  // Reference model: a FIFO of accepted entries, capacity 1 (base) or 2 (skid).
  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m_cnt8 = 0;
      m_cnt3 = 0;
    end else begin
      m_inc = !flush && ((q.size() == 0) || !out_ready);
      m_acc = in_valid && m_in_ready();
      if (flush) begin
        q.delete();
      end else begin
        if ((q.size() != 0) && out_ready) void'(q.pop_front());
        if (m_acc) q.push_back({ctrl_in, data_in});
      end
      if (clr_cnt) begin
        m_cnt8 = 0;
        m_cnt3 = 0;
      end else if (m_inc) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt3 < 7) m_cnt3++;
      end
    end
  end

  always @(negedge clk) begin
    logic [CW+DW-1:0] f;
    f = m_front();
    check("out_valid",   64'(out_valid),   64'(q.size() != 0));
    check("ctrl_out",    64'(ctrl_out),    64'(f[DW +: CW]));
    check("data_out",    data_out,         f[DW-1:0]);
    check("in_ready",    64'(in_ready),    64'(m_in_ready()));
    check("stall_cnt",   64'(stall_cnt),   64'(m_cnt8));
    check("s_out_valid", 64'(s_out_valid), 64'(q.size() != 0));
    check("s_ctrl_out",  64'(s_ctrl_out),  64'(f[DW +: CW]));
    check("s_data_out",  s_data_out,       f[DW-1:0]);
    check("s_in_ready",  64'(s_in_ready),  64'(m_in_ready()));
    check("s_stall_cnt", 64'(s_stall_cnt), 64'(m_cnt3));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    ctrl_in = 24'hABCDEF; data_in = '0;

    // Reset held with an upstream entry present
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ctrl_out",  64'(ctrl_out),  64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    reset = 1'b1;
    tick();
    check("rel_out_valid", 64'(out_valid), 64'd1);
    check("rel_ctrl_out",  64'(ctrl_out),  64'hABCDEF);
    check("rel_stall_cnt", 64'(stall_cnt), 64'd1);

    // Streaming: lane0 follows one cycle later, no stall counted
    for (int i = 1; i <= 6; i++) begin
      data_in = 64'(i);
      ctrl_in = 24'h000010 + 24'(i);
      tick();
      check("stream_lane0", 64'(data_out[7:0]), 64'(i));
    end
    check("stream_stall_cnt", 64'(stall_cnt), 64'd1);

    // Back-pressure: five stalled cycles
    data_in = 64'h5A; clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_lane0",     64'(data_out[7:0]), 64'h5A);
      check("bp_out_valid", 64'(out_valid),     64'd1);
    end
    check("bp_in_ready",  64'(in_ready),    64'd0);
    check("bp_stall_cnt", 64'(stall_cnt),   64'd5);
    check("bp_s_stall",   64'(s_stall_cnt), 64'd5);

    // Flush while full with an incoming entry
    ctrl_in = 24'h000123; data_in = 64'hFF; flush = 1'b1;
    #1;
    check("fl_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_ctrl_out",  64'(ctrl_out),  64'd0);
    check("fl_data_out",  data_out,       64'd0);
    check("fl_stall_cnt", 64'(stall_cnt), 64'd5);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // Bubbles: flushed entry never appears; narrow counter saturates
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bub_out_valid", 64'(out_valid), 64'd0);
    end
    check("sat_stall_cnt", 64'(stall_cnt),   64'd15);
    check("sat_s_stall",   64'(s_stall_cnt), 64'd7);
    clr_cnt = 1'b1;
    tick();
    check("clr_stall_cnt", 64'(stall_cnt),   64'd0);
    check("clr_s_stall",   64'(s_stall_cnt), 64'd0);
    clr_cnt = 1'b0;

    // A then B under back-pressure, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; data_in = 64'h11; ctrl_in = 24'h0000A1;
    tick();
    check("ab_lane0_a", 64'(data_out[7:0]), 64'h11);
    data_in = 64'h22; ctrl_in = 24'h0000B2;
    tick();
    check("ab_hold_a",   64'(data_out[7:0]), 64'h11);
    check("ab_in_ready", 64'(in_ready),      64'd0);
`ifdef PIPE_STAGE_SKID_EN
    in_valid = 1'b0;
`endif
    out_ready = 1'b1;
    tick();
    check("ab_lane0_b",  64'(data_out[7:0]), 64'h22);
    check("ab_ctrl_b",   64'(ctrl_out),      64'h0000B2);
    in_valid = 1'b0;
    tick();
    check("ab_drained",  64'(out_valid),     64'd0);

    // Mixed handshake pattern, including flush with out_ready asserted
    for (int i = 0; i < 16; i++) begin
      in_valid  = (i % 3) != 2;
      out_ready = (i % 4) != 1;
      flush     = (i == 7);
      data_in   = 64'h30 + 64'(i);
      ctrl_in   = 24'h000100 + 24'(i);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
